mipos_soc_mem_copy_master: RTL
==============================

// Module: mipos_soc_mem_copy_master
// PURPOSE
//  Avalon-MM master that initiates word transfers into a 32-bit single-port on-chip RAM slave.
//  The RAM slave has fixed read latency 1, no waitrequest, and 4-bit byteenable.
//  Two modes:
//   - COPY: read word at src, write it to dst.
//   - FILL: write a constant pattern.
//  Sits between a control source (CPU CSR or test logic) and the RAM slave port; the RAM is the responder.
// PARAMETERS
//  ADDR_W  12    word-address width of the RAM port
//  DEPTH   2560  number of valid 32-bit words in the RAM
//  LEN_W   12    width of the transfer length (words)
// PORTS
//  clk         in   1       system clock; all logic on rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  start       in   1       1-cycle request; sampled only in IDLE
//  mode        in   1       0=COPY, 1=FILL; sampled with start
//  src_addr    in   ADDR_W  COPY source word address
//  dst_addr    in   ADDR_W  destination word address
//  len         in   LEN_W   number of words to transfer
//  pattern     in   32      FILL data; sampled with start
//  busy        out  1       high from accepted start until the done pulse
//  done        out  1       1-cycle completion pulse
//  err         out  1       valid with done: 1 = request rejected, range error
//  m_address   out  ADDR_W  RAM word address
//  m_chipsel   out  1       RAM chipselect
//  m_write     out  1       RAM write strobe (qualified by m_chipsel)
//  m_byteen    out  4       byteenable; always 4'hF when m_chipsel=1
//  m_writedata out  32      RAM write data
//  m_readdata  in   32      RAM read data, valid 1 cycle after the read address cycle
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, err, m_chipsel, m_write = 0; m_address=0; m_byteen=0; m_writedata=0.
//  FSM states: IDLE, CHECK, RD, RD_WAIT, WR, FILL_WR, FIN.
//  IDLE
//   - On start=1, latch mode/src/dst/len/pattern and go to CHECK; busy rises in that cycle.
//   - start while busy=1 is ignored and not queued.
//  CHECK (1 cycle, no bus activity)
//   - len==0 -> FIN with err=0.
//   - dst+len>DEPTH, or (COPY and src+len>DEPTH) -> FIN with err=1. Use LEN_W+1-bit sums, no wrap.
//   - Otherwise -> RD (COPY) or FILL_WR (FILL).
//  RD
//   - Drive m_chipsel=1, m_write=0, m_address=src_cur.
//   - Go to RD_WAIT.
//  RD_WAIT
//   - Bus idle (m_chipsel=0).
//   - Capture m_readdata into the data register at the end of this cycle.
//   - Go to WR.
//  WR
//   - Drive m_chipsel=1, m_write=1, m_address=dst_cur, m_writedata=data register.
//   - Increment src_cur and dst_cur; decrement remaining count.
//   - remaining==1 -> FIN; else -> RD.
//   - COPY throughput: 3 cycles/word.
//  FILL_WR
//   - Write pattern at dst_cur every cycle; increment dst_cur.
//   - remaining==1 -> FIN.
//   - FILL throughput: 1 cycle/word.
//  FIN
//   - done=1 and err valid for exactly 1 cycle; busy drops in the same cycle.
//   - Next state IDLE; start is accepted again the cycle after FIN.
//  Bus outputs
//   - All m_* outputs are registered, glitch-free, and 0 outside RD/WR/FILL_WR.
//   - m_address holds its last value when idle.
//  Address counters never exceed DEPTH-1; the range check guarantees this.
//  Latency
//   - start at edge N -> first bus cycle at N+2.
//   - COPY done at N+2+3*len.
//   - FILL done at N+2+len.
//  Mid-operation reset: async return to reset values; a partial transfer is abandoned and no done pulse is issued.
//  m_readdata is sampled only in RD_WAIT; X on it at other times must not propagate.
// STRUCTURE
//  Shared package mipos_soc_pkg:
//   - state enum (IDLE..FIN).
//   - MODE_COPY / MODE_FILL constants.
//   - RAM_ADDR_W=12, RAM_DEPTH=2560 constants.
//  Single module; no sub-module: one FSM plus src/dst/remaining counters and a data register.
// TESTING
//  COPY, src=0x010, dst=0x100, len=4, RAM[0x10..0x13]=1,2,3,4
//   -> RAM[0x100..0x103]=1,2,3,4; done at N+14; err=0.
//  FILL, dst=0x9FD, len=3, pattern=0xDEADBEEF
//   -> RAM[0x9FD..0x9FF]=0xDEADBEEF; 3 consecutive write cycles; done at N+5.
//  len=0 (either mode)
//   -> no m_chipsel activity; done at N+2; err=0.
//  COPY, src=0x9FF, len=2
//   -> done+err=1 at N+2; no bus access; RAM unchanged.
//  start pulsed during a busy COPY
//   -> ignored; only the first transfer completes; exactly one done pulse.
//  reset_n low for 1 cycle mid-COPY (after word 2 of 4)
//   -> outputs immediately 0; no done pulse; a new start afterwards works normally.

Source files
------------

// File: rtl/mipos_soc_pkg.sv
// Shared types and constants for the mipos SoC memory-copy master.
package mipos_soc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RD,
    RD_WAIT,
    WR,
    FILL_WR,
    FIN
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam int RAM_ADDR_W = 12;
  localparam int RAM_DEPTH  = 2560;

endpackage

// File: rtl/mipos_soc_mem_copy_master.sv
// Avalon-MM master that copies or fills word ranges in a latency-1 on-chip RAM.
module mipos_soc_mem_copy_master
  import mipos_soc_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = RAM_DEPTH,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [31:0]       pattern,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipsel,
  output logic              m_write,
  output logic [3:0]        m_byteen,
  output logic [31:0]       m_writedata,
  input  logic [31:0]       m_readdata
);

  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

  state_t            state_reg, state_next;
  logic              mode_reg;
  logic [ADDR_W-1:0] src_reg, dst_reg;
  logic [LEN_W-1:0]  rem_reg;
  logic [31:0]       pattern_reg;
  logic              busy_reg, done_reg, err_reg;
  logic [ADDR_W-1:0] m_address_reg;
  logic              m_chipsel_reg, m_write_reg;
  logic [3:0]        m_byteen_reg;
  logic [31:0]       m_writedata_reg;

  // Range check on widened sums so an end address past the top never wraps.
  logic [SUM_W-1:0] dst_end, src_end;
  logic             range_err;
  assign dst_end   = SUM_W'(dst_reg) + SUM_W'(rem_reg);
  assign src_end   = SUM_W'(src_reg) + SUM_W'(rem_reg);
  assign range_err = (dst_end > SUM_W'(DEPTH)) ||
                     ((mode_reg == MODE_COPY) && (src_end > SUM_W'(DEPTH)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // rem_reg is decremented on entry to each write cycle, so zero here means last word.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CHECK;
      CHECK: begin
        if (rem_reg == '0)             state_next = FIN;
        else if (range_err)            state_next = FIN;
        else if (mode_reg == MODE_COPY) state_next = RD;
        else                           state_next = FILL_WR;
      end
      RD:      state_next = RD_WAIT;
      RD_WAIT: state_next = WR;
      WR:      state_next = (rem_reg == '0) ? FIN : RD;
      FILL_WR: state_next = (rem_reg == '0) ? FIN : FILL_WR;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs are loaded from the next state so they are clean flop outputs;
  // m_writedata doubles as the copy data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_reg        <= MODE_COPY;
      src_reg         <= '0;
      dst_reg         <= '0;
      rem_reg         <= '0;
      pattern_reg     <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      m_address_reg   <= '0;
      m_chipsel_reg   <= 1'b0;
      m_write_reg     <= 1'b0;
      m_byteen_reg    <= 4'h0;
      m_writedata_reg <= '0;
    end else begin
      m_chipsel_reg   <= 1'b0;
      m_write_reg     <= 1'b0;
      m_byteen_reg    <= 4'h0;
      m_writedata_reg <= '0;
      busy_reg        <= state_next inside {CHECK, RD, RD_WAIT, WR, FILL_WR};
      done_reg        <= (state_next == FIN);
      err_reg         <= (state_reg == CHECK) && (rem_reg != '0) && range_err;

      if (state_reg == IDLE && start) begin
        mode_reg    <= mode;
        src_reg     <= src_addr;
        dst_reg     <= dst_addr;
        rem_reg     <= len;
        pattern_reg <= pattern;
      end

      case (state_next)
        RD: begin
          m_chipsel_reg <= 1'b1;
          m_byteen_reg  <= 4'hF;
          m_address_reg <= src_reg;
          if (rem_reg != LEN_W'(1)) src_reg <= src_reg + ADDR_W'(1);
        end
        WR, FILL_WR: begin
          m_chipsel_reg   <= 1'b1;
          m_write_reg     <= 1'b1;
          m_byteen_reg    <= 4'hF;
          m_address_reg   <= dst_reg;
          m_writedata_reg <= (state_next == WR) ? m_readdata : pattern_reg;
          rem_reg         <= rem_reg - LEN_W'(1);
          // Counters stop on the last word so they never pass DEPTH-1.
          if (rem_reg != LEN_W'(1)) dst_reg <= dst_reg + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign m_address   = m_address_reg;
  assign m_chipsel   = m_chipsel_reg;
  assign m_write     = m_write_reg;
  assign m_byteen    = m_byteen_reg;
  assign m_writedata = m_writedata_reg;

endmodule
